// File: rtl/fade_sequencer.sv
// rtl/fade_sequencer.sv - gamma-corrected LED fade sequencer driving the PWM8 duty input
//
// Walks a 16-entry gamma table up, holds at full brightness, walks back down,
// then either stops (one-shot) or holds dark and repeats (continuous).
// Duty only changes on PWM period boundaries (PwmQ == 255), so the PWM
// always sees a stable duty for a whole period.
//
// Optional build macro: FADE_BRIGHT_SCALE_EN adds the Scale input and
// multiplies every table entry by (Scale+1)/256.
//
// Ports:
//   Clock   in   system clock, rising edge
//   Reset   in   synchronous active-high reset
//   Enable  in   1 = run, 0 = freeze everything (Start/Stop ignored)
//   Start   in   request a fade cycle (honoured only in IDLE)
//   Stop    in   abort request, wins over Start
//   Mode    in   0 = one-shot, 1 = continuous loop
//   PwmQ    in   [7:0] PWM8 period counter
//   Scale   in   [7:0] brightness scale (FADE_BRIGHT_SCALE_EN only)
//   Duty    out  [7:0] registered duty value for PWM8
//   Index   out  [3:0] registered gamma table index
//   Busy    out  registered, high when running or a start is pending
//   Done    out  one-cycle pulse when a one-shot fade completes

module fade_sequencer #(
    parameter int STEP_PERIODS = 4,
    parameter int HOLD_PERIODS = 32
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Enable,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Mode,
    input  logic [7:0] PwmQ,
`ifdef FADE_BRIGHT_SCALE_EN
    input  logic [7:0] Scale,
`endif
    output logic [7:0] Duty,
    output logic [3:0] Index,
    output logic       Busy,
    output logic       Done
);

    typedef enum logic [2:0] {
        IDLE,
        RAMP_UP,
        HOLD_HIGH,
        RAMP_DOWN,
        HOLD_LOW
    } state_t;

    // Counters compare against PARAM-1, so they never need to wrap.
    localparam logic [15:0] STEP_LAST = 16'(STEP_PERIODS - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_PERIODS - 1);

    state_t      state;
    logic [15:0] count;
    logic        start_pending;
    logic        stop_pending;
    logic        tick;
    logic        start_req;
    logic        stop_req;

    assign tick      = Enable && (PwmQ == 8'd255);
    assign start_req = Enable && Start && !Stop && (state == IDLE) && !stop_pending;
    assign stop_req  = Enable && Stop && ((state != IDLE) || start_pending);

    function automatic logic [7:0] lut(input logic [3:0] i);
        case (i)
            4'd0:    return 8'd0;
            4'd1:    return 8'd1;
            4'd2:    return 8'd2;
            4'd3:    return 8'd4;
            4'd4:    return 8'd6;
            4'd5:    return 8'd10;
            4'd6:    return 8'd15;
            4'd7:    return 8'd22;
            4'd8:    return 8'd31;
            4'd9:    return 8'd43;
            4'd10:   return 8'd58;
            4'd11:   return 8'd77;
            4'd12:   return 8'd100;
            4'd13:   return 8'd129;
            4'd14:   return 8'd164;
            default: return 8'd255;
        endcase
    endfunction

    // Only called from tick branches, so Scale is effectively sampled on ticks.
    function automatic logic [7:0] duty_of(input logic [3:0] i);
`ifdef FADE_BRIGHT_SCALE_EN
        logic [15:0] product;
        product = {8'd0, lut(i)} * ({8'd0, Scale} + 16'd1);
        return product[15:8];
`else
        return lut(i);
`endif
    endfunction

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= IDLE;
            count         <= 16'd0;
            start_pending <= 1'b0;
            stop_pending  <= 1'b0;
            Duty          <= 8'd0;
            Index         <= 4'd0;
            Busy          <= 1'b0;
            Done          <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (start_req) begin
                start_pending <= 1'b1;
                Busy          <= 1'b1;
            end
            if (stop_req) begin
                stop_pending <= 1'b1;
            end
            if (tick) begin
                if (stop_pending) begin
                    // Abort: silent return to IDLE, no Done pulse.
                    state         <= IDLE;
                    count         <= 16'd0;
                    start_pending <= 1'b0;
                    stop_pending  <= 1'b0;
                    Duty          <= 8'd0;
                    Index         <= 4'd0;
                    Busy          <= 1'b0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (start_pending) begin
                                state         <= RAMP_UP;
                                start_pending <= 1'b0;
                                count         <= 16'd0;
                                Index         <= 4'd0;
                                Duty          <= duty_of(4'd0);
                            end
                        end
                        RAMP_UP: begin
                            if (count == STEP_LAST) begin
                                count <= 16'd0;
                                if (Index != 4'd15) begin
                                    Index <= Index + 4'd1;
                                    Duty  <= duty_of(Index + 4'd1);
                                end else begin
                                    state <= HOLD_HIGH;
                                    Duty  <= duty_of(4'd15);
                                end
                            end else begin
                                count <= count + 16'd1;
                                Duty  <= duty_of(Index);
                            end
                        end
                        HOLD_HIGH: begin
                            if (count == HOLD_LAST) begin
                                state <= RAMP_DOWN;
                                count <= 16'd0;
                                Index <= 4'd14;
                                Duty  <= duty_of(4'd14);
                            end else begin
                                count <= count + 16'd1;
                                Duty  <= duty_of(Index);
                            end
                        end
                        RAMP_DOWN: begin
                            if (count == STEP_LAST) begin
                                count <= 16'd0;
                                if (Index != 4'd0) begin
                                    Index <= Index - 4'd1;
                                    Duty  <= duty_of(Index - 4'd1);
                                end else if (Mode) begin
                                    state <= HOLD_LOW;
                                    Duty  <= 8'd0;
                                end else begin
                                    state <= IDLE;
                                    Duty  <= 8'd0;
                                    Busy  <= 1'b0;
                                    Done  <= 1'b1;
                                end
                            end else begin
                                count <= count + 16'd1;
                                Duty  <= duty_of(Index);
                            end
                        end
                        HOLD_LOW: begin
                            if (count == HOLD_LAST) begin
                                state <= RAMP_UP;
                                count <= 16'd0;
                                Index <= 4'd0;
                                Duty  <= duty_of(4'd0);
                            end else begin
                                count <= count + 16'd1;
                            end
                        end
                        default: begin
                            state <= IDLE;
                            count <= 16'd0;
                            Duty  <= 8'd0;
                            Index <= 4'd0;
                            Busy  <= start_pending;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_fade_sequencer.sv
// tb/tb_fade_sequencer.sv - self-checking bench for fade_sequencer

module tb_fade_sequencer;

    localparam int S = 2;
    localparam int H = 3;
    localparam int UP_END   = 16 * S;
    localparam int HH_END   = UP_END + H;
    localparam int DN_END   = HH_END + 15 * S;
    localparam int LOOP_LEN = DN_END + H;
    localparam int LUT[16] = '{0, 1, 2, 4, 6, 10, 15, 22, 31, 43, 58, 77, 100, 129, 164, 255};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       start = 1'b1;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] pwm_q = 8'd0;
    logic [7:0] duty;
    logic [3:0] index;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    fade_sequencer #(.STEP_PERIODS(S), .HOLD_PERIODS(H)) dut (
        .Clock  (clk),
        .Reset  (reset),
        .Enable (enable),
        .Start  (start),
        .Stop   (stop),
        .Mode   (mode),
        .PwmQ   (pwm_q),
        .Duty   (duty),
        .Index  (index),
        .Busy   (busy),
        .Done   (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pwm_q <= pwm_q + 8'd1;

    // Duty may only move on a tick edge (or under reset).
    logic       edge_tick = 1'b0;
    logic       edge_rst  = 1'b0;
    logic [7:0] last_duty = 8'd0;
    always @(posedge clk) begin
        edge_tick <= enable && (pwm_q == 8'd255);
        edge_rst  <= reset;
    end
    always @(negedge clk) begin
        if (duty !== last_duty) begin
            checks++;
            assert (edge_tick || edge_rst) else begin
                errors++;
                $error("FAIL duty_off_tick observed=%0d expected=%0d", duty, last_duty);
            end
        end
        last_duty = duty;
    end

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: position within a fade counted in enabled ticks since RAMP_UP entry.
    function automatic int fade_index(input int k, input bit loop);
        int p;
        p = loop ? (k % LOOP_LEN) : k;
        if (p < UP_END) return p / S;
        if (p < HH_END) return 15;
        if (p < DN_END) return 14 - (p - HH_END) / S;
        return 0;
    endfunction

    // Return #1 after the next posedge at which PwmQ == 255.
    task automatic goto_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pwm_q != 8'd255 && n < 300);
        if (n >= 300) check("tick_timeout", n, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_ticks(input int from, input int to, input bit loop, input string tag);
        int idx;
        for (int k = from; k <= to; k++) begin
            goto_tick();
            idx = fade_index(k, loop);
            check($sformatf("%s_index_t%0d", tag, k), int'(index), idx);
            check($sformatf("%s_duty_t%0d", tag, k), int'(duty), LUT[idx]);
            check($sformatf("%s_busy_t%0d", tag, k), int'(busy), (loop || k < DN_END) ? 1 : 0);
            check($sformatf("%s_done_t%0d", tag, k), int'(done), (!loop && k == DN_END) ? 1 : 0);
        end
    endtask

    initial begin
        int r;
        int n_off;

        // Reset held with Start asserted stays IDLE.
        repeat (3) @(posedge clk);
        #1;
        check("rst_duty", int'(duty), 0);
        check("rst_index", int'(index), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        reset = 1'b0;
        start = 1'b0;
        goto_tick();
        check("rst_idle_busy", int'(busy), 0);

        // One-shot fade from a random phase of the PWM period.
        repeat ($urandom_range(0, 255)) @(posedge clk);
        mode = 1'b0;
        pulse_start();
        check("os_busy_after_start", int'(busy), 1);
        run_ticks(0, DN_END, 1'b0, "os");
        @(posedge clk);
        #1;
        check("os_done_cleared", int'(done), 0);
        check("os_busy_idle", int'(busy), 0);

        // Continuous: hold low, restart with no gap.
        repeat ($urandom_range(0, 255)) @(posedge clk);
        mode = 1'b1;
        pulse_start();
        run_ticks(0, LOOP_LEN + 4, 1'b1, "loop");
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        mode = 1'b0;
        goto_tick();
        check("loop_stop_index", int'(index), 0);
        check("loop_stop_busy", int'(busy), 0);
        check("loop_stop_done", int'(done), 0);

        // Stop mid-ramp at a random tick.
        r = $urandom_range(5, 30);
        pulse_start();
        run_ticks(0, r, 1'b0, "stp");
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        check("stp_busy_pending", int'(busy), 1);
        check("stp_index_pending", int'(index), fade_index(r, 1'b0));
        goto_tick();
        check("stp_duty", int'(duty), 0);
        check("stp_index", int'(index), 0);
        check("stp_busy", int'(busy), 0);
        check("stp_done", int'(done), 0);

        // Start and Stop together in IDLE: Stop wins.
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        check("ss_busy", int'(busy), 0);
        goto_tick();
        check("ss_busy_tick", int'(busy), 0);
        check("ss_index_tick", int'(index), 0);

        // Enable freeze at Index 5; Start/Stop ignored while frozen.
        pulse_start();
        run_ticks(0, 10, 1'b0, "en_pre");
        enable = 1'b0;
        n_off = $urandom_range(2, 6);
        for (int i = 0; i < n_off; i++) begin
            goto_tick();
            if (i == 0) begin
                stop  = 1'b1;
                start = 1'b1;
                @(posedge clk);
                #1;
                stop  = 1'b0;
                start = 1'b0;
            end
            check($sformatf("en_frz_index_%0d", i), int'(index), 5);
            check($sformatf("en_frz_duty_%0d", i), int'(duty), 10);
            check($sformatf("en_frz_busy_%0d", i), int'(busy), 1);
        end
        enable = 1'b1;
        run_ticks(11, DN_END, 1'b0, "en_post");

        // Reset mid-ramp with Start held.
        pulse_start();
        r = $urandom_range(4, 20);
        run_ticks(0, r, 1'b0, "mr");
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mr_duty", int'(duty), 0);
        check("mr_index", int'(index), 0);
        check("mr_busy", int'(busy), 0);
        check("mr_done", int'(done), 0);
        reset = 1'b0;
        start = 1'b0;
        goto_tick();
        goto_tick();
        check("mr_idle_busy", int'(busy), 0);
        check("mr_idle_index", int'(index), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
